// File: rtl/dcache_m.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Sits between the core's data port and a slower req/ack backing memory.
module dcache_m #(
  parameter int WIDTH = 12,
  parameter int INDEX = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [31:0]      i_data,
  output logic [31:0]      o_data,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [31:0]      o_mem_data,
  input  logic [31:0]      i_mem_data,
  input  logic             i_mem_ack
);

  localparam int LINES = 1 << INDEX;
  localparam int TAGW  = WIDTH - INDEX;

  typedef enum logic [1:0] {IDLE, TAG, FILL, WRITE} state_t;

  state_t           state;
  logic [WIDTH-1:0] addr_q;
  logic             we_q;
  logic [31:0]      data_q;
  logic             hit_q;

  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [31:0]      line_q [LINES];

  logic [INDEX-1:0] idx;
  logic [TAGW-1:0]  addr_tag;
  logic             hit;

  assign idx        = addr_q[INDEX-1:0];
  assign addr_tag   = addr_q[WIDTH-1:INDEX];
  assign hit        = valid_q[idx] && (tag_q[idx] == addr_tag);
  assign o_busy     = (state != IDLE);
  assign o_mem_addr = addr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      valid_q    <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      hit_q      <= 1'b0;
      o_data     <= '0;
      o_ready    <= 1'b0;
      o_mem_req  <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_data <= '0;
    end else begin
      o_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            addr_q <= i_addr;
            we_q   <= i_we;
            data_q <= i_data;
            state  <= TAG;
          end
        end
        TAG: begin
          hit_q <= hit;
          if (!we_q && hit) begin
            o_data  <= line_q[idx];
            o_ready <= 1'b1;
            state   <= IDLE;
          end else begin
            // Every write goes through to memory; only reads that miss fill.
            o_mem_req <= 1'b1;
            o_mem_we  <= we_q;
            if (we_q) o_mem_data <= data_q;
            state <= we_q ? WRITE : FILL;
          end
        end
        FILL: begin
          if (i_mem_ack) begin
            line_q[idx]  <= i_mem_data;
            tag_q[idx]   <= addr_tag;
            valid_q[idx] <= 1'b1;
            o_data       <= i_mem_data;
            o_ready      <= 1'b1;
            o_mem_req    <= 1'b0;
            state        <= IDLE;
          end
        end
        WRITE: begin
          if (i_mem_ack) begin
            if (hit_q) line_q[idx] <= data_q;
            o_ready   <= 1'b1;
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
